// File: rtl/alu_shift_seq_pkg.sv
// ============================================================================
// Module  : alu_shift_seq_pkg
// Purpose : Mode and FSM state encodings shared by the shift/rotate/swap unit.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_shift_seq_pkg;

    typedef enum logic [2:0] {
        SH_LSR  = 3'd0,
        SH_ASR  = 3'd1,
        SH_RRC  = 3'd2,
        SH_LSL  = 3'd3,
        SH_RLC  = 3'd4,
        SH_ROR  = 3'd5,
        SH_SWAP = 3'd6,
        SH_PASS = 3'd7
    } sh_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } sh_state_t;

endpackage

`default_nettype wire

// File: rtl/alu_shift_step.sv
// ============================================================================
// Module  : alu_shift_step
// Purpose : Combinational single-step shift/rotate/swap unit; all per-mode
//           bit manipulation lives here.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_shift_step
    import alu_shift_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  sh_mode_t           op,
    input  logic [WIDTH-1:0]   res,
    input  logic               c,
    output logic [WIDTH-1:0]   res_nxt,
    output logic               c_nxt
);

    always_comb begin
        res_nxt = res;
        c_nxt   = c;
        case (op)
            SH_LSR: begin
                res_nxt = {1'b0, res[WIDTH-1:1]};
                c_nxt   = res[0];
            end
            SH_ASR: begin
                res_nxt = {res[WIDTH-1], res[WIDTH-1:1]};
                c_nxt   = res[0];
            end
            SH_RRC: begin
                res_nxt = {c, res[WIDTH-1:1]};
                c_nxt   = res[0];
            end
            SH_LSL: begin
                res_nxt = {res[WIDTH-2:0], 1'b0};
                c_nxt   = res[WIDTH-1];
            end
            SH_RLC: begin
                res_nxt = {res[WIDTH-2:0], c};
                c_nxt   = res[WIDTH-1];
            end
            SH_ROR: begin
                res_nxt = {res[0], res[WIDTH-1:1]};
                c_nxt   = res[0];
            end
            // Carry is untouched so it still holds the captured carry-in.
            SH_SWAP: begin
                res_nxt = {res[WIDTH/2-1:0], res[WIDTH-1:WIDTH/2]};
            end
            default: begin
                res_nxt = res;
                c_nxt   = c;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/alu_shift_seq.sv
// ============================================================================
// Module  : alu_shift_seq
// Purpose : Multi-cycle shift/rotate/swap unit, one bit per clock, with the
//           registered result driven onto a shared tri-state bus.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_shift_seq
    import alu_shift_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [2:0]         mode,
    input  logic [AMT_W-1:0]   amount,
    input  logic [WIDTH-1:0]   arg,
    input  logic               cin,
    input  logic               outn,
    output logic               busy,
    output logic               done,
    output wire  [WIDTH-1:0]   bus,
    output wire                cout,
    output logic               zero
);

    sh_state_t          r_state;
    sh_state_t          w_state_nxt;
    logic [WIDTH-1:0]   r_res;
    logic               r_c;
    logic [AMT_W-1:0]   r_cnt;
    sh_mode_t           r_op;

    sh_mode_t           w_mode;
    logic [AMT_W-1:0]   w_load_cnt;
    logic               w_load;
    logic [WIDTH-1:0]   w_res_step;
    logic               w_c_step;

    assign w_mode = sh_mode_t'(mode);

    // SWAP is a single fixed step; PASS completes without shifting.
    always_comb begin
        w_load_cnt = amount;
        if (w_mode == SH_SWAP) begin
            w_load_cnt = AMT_W'(1);
        end else if (w_mode == SH_PASS) begin
            w_load_cnt = '0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = (w_load_cnt != '0) ? ST_SHIFT : ST_DONE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (r_cnt == AMT_W'(1)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_res <= '0;
            r_c   <= 1'b0;
            r_cnt <= '0;
            r_op  <= SH_PASS;
        end else if (w_load) begin
            r_res <= arg;
            r_c   <= cin;
            r_op  <= w_mode;
            r_cnt <= w_load_cnt;
        end else if (r_state == ST_SHIFT) begin
            r_res <= w_res_step;
            r_c   <= w_c_step;
            r_cnt <= r_cnt - AMT_W'(1);
        end
    end

    alu_shift_step #(
        .WIDTH   (WIDTH)
    ) u_step (
        .op      (r_op),
        .res     (r_res),
        .c       (r_c),
        .res_nxt (w_res_step),
        .c_nxt   (w_c_step)
    );

    assign busy = (r_state == ST_SHIFT);
    assign done = (r_state == ST_DONE);
    assign zero = (r_res == '0);

    assign bus  = outn ? {WIDTH{1'bz}} : r_res;
    assign cout = outn ? 1'bz : r_c;

endmodule

`default_nettype wire
